// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register (negedge-updated) with stall bubbles, flush, and a saturating bubble counter.
// Optional one-entry skid buffer under ID_EX_SKID_BUFFER_EN; latency 1 edge, bubbles always carry zero control.
module id_ex_stage_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1,
  output logic [XLEN-1:0]   out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic [XLEN-1:0]   out_instr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   instr;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  // Encoding is {skid_valid, out_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  state_t           state, state_nxt;
  entry_t           main_q, main_d, in_ent;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer;

  assign in_ent  = {in_pc, in_rs1, in_rs2, in_imm, in_instr, in_ctrl};
  assign in_xfer = in_valid && in_ready;

`ifdef ID_EX_SKID_BUFFER_EN
  entry_t skid_q, skid_d;

  assign in_ready = !state[1] && !stall && !flush;

  always_comb begin
    state_nxt = state;
    main_d    = main_q;
    skid_d    = skid_q;
    if (flush) begin
      state_nxt   = EMPTY;
      main_d.ctrl = '0;
    end else if (stall) begin
      if (out_ready || !state[0]) begin
        if (state == SKID) begin
          state_nxt = FULL;
          main_d    = skid_q;
        end else begin
          state_nxt   = EMPTY;
          main_d.ctrl = '0;
        end
      end
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state_nxt = FULL;
            main_d    = in_ent;
          end
        end
        FULL: begin
          if (in_xfer && out_ready) begin
            main_d = in_ent;
          end else if (in_xfer) begin
            // EX refused the held entry, so the new one parks in the skid slot.
            state_nxt = SKID;
            skid_d    = in_ent;
          end else if (out_ready) begin
            state_nxt   = EMPTY;
            main_d.ctrl = '0;
          end
        end
        SKID: begin
          if (out_ready) begin
            state_nxt = FULL;
            main_d    = skid_q;
          end
        end
        default: begin
          state_nxt   = EMPTY;
          main_d.ctrl = '0;
        end
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (reset) skid_q <= '0;
    else       skid_q <= skid_d;
  end
`else
  logic out_xfer;

  assign out_xfer = state[0] && out_ready;
  assign in_ready = !stall && !flush && (!state[0] || out_ready);

  always_comb begin
    state_nxt = state;
    main_d    = main_q;
    if (flush) begin
      state_nxt   = EMPTY;
      main_d.ctrl = '0;
    end else if (stall) begin
      if (out_ready || !state[0]) begin
        state_nxt   = EMPTY;
        main_d.ctrl = '0;
      end
    end else if (in_xfer) begin
      state_nxt = FULL;
      main_d    = in_ent;
    end else if (out_xfer) begin
      state_nxt   = EMPTY;
      main_d.ctrl = '0;
    end
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (!state_nxt[0] && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      cnt_q  <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid  = state[0];
  assign out_pc     = main_q.pc;
  assign out_rs1    = main_q.rs1;
  assign out_rs2    = main_q.rs2;
  assign out_imm    = main_q.imm;
  assign out_instr  = main_q.instr;
  assign out_ctrl   = main_q.ctrl;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, streaming, load-use stall, flush, back-pressure, counter saturation.
module tb_id_ex_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm, in_instr;
  logic [11:0] in_ctrl;
  logic        stall, flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_rs1, out_rs2, out_imm, out_instr;
  logic [11:0] out_ctrl;
  logic [15:0] bubble_cnt;

  logic        sat_reset;
  logic        sat_in_valid;
  logic        sat_in_ready, sat_out_valid;
  logic [31:0] sat_out_pc, sat_out_rs1, sat_out_rs2, sat_out_imm, sat_out_instr;
  logic [11:0] sat_out_ctrl;
  logic [3:0]  sat_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_instr(in_instr), .in_ctrl(in_ctrl), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_instr(out_instr), .out_ctrl(out_ctrl), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage_reg #(.XLEN(32), .CTRL_W(12), .CNT_W(4)) sat_dut (
    .clk(clk), .reset(sat_reset), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_instr(in_instr), .in_ctrl(in_ctrl), .stall(1'b0), .flush(1'b0),
    .out_valid(sat_out_valid), .out_ready(1'b1), .out_pc(sat_out_pc),
    .out_rs1(sat_out_rs1), .out_rs2(sat_out_rs2), .out_imm(sat_out_imm),
    .out_instr(sat_out_instr), .out_ctrl(sat_out_ctrl), .bubble_cnt(sat_cnt)
  );

  // State changes on negedge; outputs are sampled and inputs driven just after the posedge.
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [11:0] ctrl);
    in_valid = v;
    in_pc    = pc;
    in_rs1   = pc + 32'h1;
    in_rs2   = pc + 32'h2;
    in_imm   = pc ^ 32'hFFFF_0000;
    in_instr = {pc[15:0], 16'h0013};
    in_ctrl  = ctrl;
  endtask

  task automatic test_reset();
    reset = 1'b1; sat_reset = 1'b1; sat_in_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 12'hFFF);
    tick();
    tick();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_ctrl !== 12'h000) $display("FAIL reset_ctrl got %h want 000", out_ctrl); else pass_cnt++;
    chk_cnt++;
    if ({out_pc, out_rs1, out_rs2, out_imm, out_instr} !== 160'h0)
      $display("FAIL reset_payload got pc=%h rs1=%h want all zero", out_pc, out_rs1);
    else pass_cnt++;
    chk_cnt++; if (bubble_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", bubble_cnt); else pass_cnt++;
    reset = 1'b0;
    drive(1'b0, 32'h0, 12'h0);
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_streaming();
    drive(1'b1, 32'h100, 12'h801);
    tick();
    chk_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_ctrl !== 12'h801)
      $display("FAIL stream_0 got v=%0b pc=%h ctrl=%h want 1 100 801", out_valid, out_pc, out_ctrl);
    else pass_cnt++;
    drive(1'b1, 32'h104, 12'h9A4);
    tick();
    chk_cnt++;
    if (out_pc !== 32'h104 || out_ctrl !== 12'h9A4)
      $display("FAIL stream_1 got pc=%h ctrl=%h want 104 9a4", out_pc, out_ctrl);
    else pass_cnt++;
    drive(1'b1, 32'h108, 12'h5F0);
    tick();
    chk_cnt++;
    if (out_pc !== 32'h108 || out_rs1 !== 32'h109 || out_rs2 !== 32'h10A ||
        out_imm !== 32'hFFFF_0108 || out_instr !== 32'h0108_0013 || out_ctrl !== 12'h5F0)
      $display("FAIL stream_2 got pc=%h rs1=%h rs2=%h imm=%h instr=%h ctrl=%h",
               out_pc, out_rs1, out_rs2, out_imm, out_instr, out_ctrl);
    else pass_cnt++;
    chk_cnt++; if (bubble_cnt !== 16'd0) $display("FAIL stream_cnt got %0d want 0", bubble_cnt); else pass_cnt++;
  endtask

  task automatic test_load_use();
    drive(1'b1, 32'h200, 12'h7F3);
    tick();
    chk_cnt++; if (out_pc !== 32'h200 || out_valid !== 1'b1) $display("FAIL lu_load got pc=%h v=%0b want 200 1", out_pc, out_valid); else pass_cnt++;
    drive(1'b1, 32'h204, 12'h3C1);
    stall = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL lu_in_ready got %0b want 0", in_ready); else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0 || out_ctrl !== 12'h000 || bubble_cnt !== 16'd1)
      $display("FAIL lu_bubble got v=%0b ctrl=%h cnt=%0d want 0 000 1", out_valid, out_ctrl, bubble_cnt);
    else pass_cnt++;
    stall = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL lu_release got %0b want 1", in_ready); else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_ctrl !== 12'h3C1 || bubble_cnt !== 16'd1)
      $display("FAIL lu_resume got v=%0b pc=%h ctrl=%h cnt=%0d want 1 204 3c1 1", out_valid, out_pc, out_ctrl, bubble_cnt);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h300, 12'hABC);
    flush = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %0b want 0", in_ready); else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0 || out_ctrl !== 12'h000 || out_pc !== 32'h204 || bubble_cnt !== 16'd2)
      $display("FAIL flush_kill got v=%0b ctrl=%h pc=%h cnt=%0d want 0 000 204 2", out_valid, out_ctrl, out_pc, bubble_cnt);
    else pass_cnt++;
    flush = 1'b0;
    drive(1'b0, 32'h0, 12'h0);
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0 || out_pc === 32'h300 || bubble_cnt !== 16'd3)
      $display("FAIL flush_after got v=%0b pc=%h cnt=%0d want 0 !300 3", out_valid, out_pc, bubble_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h400, 12'h111);
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_empty_ready got %0b want 1", in_ready); else pass_cnt++;
    tick();
    drive(1'b1, 32'h404, 12'h222);
    #1;
`ifdef ID_EX_SKID_BUFFER_EN
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_skid_free got %0b want 1", in_ready); else pass_cnt++;
    tick();
    drive(1'b1, 32'h408, 12'h333);
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_skid_full got %0b want 0", in_ready); else pass_cnt++;
    drive(1'b0, 32'h0, 12'h0);
`else
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_blocked got %0b want 0", in_ready); else pass_cnt++;
    tick();
    out_ready = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_comb_ready got %0b want 1", in_ready); else pass_cnt++;
    out_ready = 1'b0;
`endif
    chk_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h400 || out_ctrl !== 12'h111)
      $display("FAIL bp_hold got v=%0b pc=%h ctrl=%h want 1 400 111", out_valid, out_pc, out_ctrl);
    else pass_cnt++;
    out_ready = 1'b1;
    tick();
`ifndef ID_EX_SKID_BUFFER_EN
    drive(1'b0, 32'h0, 12'h0);
`endif
    chk_cnt++;
    if (out_valid !== 1'b1 || out_pc !== 32'h404 || out_ctrl !== 12'h222)
      $display("FAIL bp_second got v=%0b pc=%h ctrl=%h want 1 404 222", out_valid, out_pc, out_ctrl);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0 || bubble_cnt !== 16'd4)
      $display("FAIL bp_drain got v=%0b cnt=%0d want 0 4", out_valid, bubble_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h500, 12'h444);
    tick();
    reset = 1'b1;
    drive(1'b1, 32'h504, 12'h555);
    tick();
    chk_cnt++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_ctrl !== 12'h0 || bubble_cnt !== 16'd0)
      $display("FAIL mid_reset got v=%0b pc=%h ctrl=%h cnt=%0d want 0 0 0 0", out_valid, out_pc, out_ctrl, bubble_cnt);
    else pass_cnt++;
    reset = 1'b0;
    drive(1'b0, 32'h0, 12'h0);
  endtask

  task automatic test_saturation();
    sat_reset = 1'b0;
    repeat (14) tick();
    chk_cnt++; if (sat_cnt !== 4'd14) $display("FAIL sat_pre got %0d want 14", sat_cnt); else pass_cnt++;
    repeat (6) tick();
    chk_cnt++;
    if (sat_cnt !== 4'd15 || sat_out_valid !== 1'b0)
      $display("FAIL sat_hold got cnt=%0d v=%0b want 15 0", sat_cnt, sat_out_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_load_use();
    test_flush();
    test_back_pressure();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
